// File: rtl/led_status_driver.sv
`default_nettype none
// ============================================================================
// Module   : led_status_driver
// Purpose  : Multi-channel LED status driver with shared tick prescaler and
//            per-channel off / follow / blink / pulse-code modes.
//            Optional PWM dimming is enabled by defining LED_STATUS_PWM_EN.
// Revision : 1.0
// ============================================================================
module led_status_driver #(
   parameter int NUM_LEDS       = 8,
   parameter int PRESCALE       = 83000,
   parameter int PRESCALE_WIDTH = 17,
   parameter int PERIOD_WIDTH   = 10,
   parameter int GAP_MULT       = 4
) (
   input  logic                    int_clock,
   input  logic                    int_reset,
   input  logic [NUM_LEDS-1:0]     led_in,
   input  logic                    cfg_write,
   input  logic [3:0]              cfg_channel,
   input  logic [1:0]              cfg_mode,
   input  logic [PERIOD_WIDTH-1:0] cfg_period,
   input  logic [3:0]              cfg_count,
   input  logic [3:0]              brightness,
   output logic                    tick,
   output logic [NUM_LEDS-1:0]     leds
);

   localparam int C_PHASE_WIDTH = PERIOD_WIDTH + $clog2(GAP_MULT);
   localparam logic [PRESCALE_WIDTH-1:0] C_PRESCALE_LAST = PRESCALE_WIDTH'(PRESCALE - 1);
   localparam logic [C_PHASE_WIDTH-1:0]  C_GAP_MULT      = C_PHASE_WIDTH'(GAP_MULT);
   localparam logic [1:0] C_MODE_OFF    = 2'd0;
   localparam logic [1:0] C_MODE_FOLLOW = 2'd1;
   localparam logic [1:0] C_MODE_BLINK  = 2'd2;
   localparam logic [1:0] C_MODE_CODE   = 2'd3;

   typedef enum logic [1:0] {
      ST_ON  = 2'd0,
      ST_OFF = 2'd1,
      ST_GAP = 2'd2
   } chan_state_t;

   logic [PRESCALE_WIDTH-1:0] r_prescale;
   logic                      r_tick;

   always_ff @(posedge int_clock) begin
      if (!int_reset) begin
         r_prescale <= '0;
         r_tick     <= 1'b0;
      end else if (r_prescale == C_PRESCALE_LAST) begin
         r_prescale <= '0;
         r_tick     <= 1'b1;
      end else begin
         r_prescale <= r_prescale + 1'b1;
         r_tick     <= 1'b0;
      end
   end

   assign tick = r_tick;

   logic [NUM_LEDS-1:0] w_lit;
   logic [NUM_LEDS-1:0] w_sel;
   logic [NUM_LEDS-1:0] w_restart_lit;

   generate
      for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
         logic [1:0]               r_mode;
         logic [PERIOD_WIDTH-1:0]  r_period;
         logic [3:0]               r_count;
         logic [C_PHASE_WIDTH-1:0] r_phase;
         logic [3:0]               r_pulse;
         chan_state_t              r_state;
         logic [C_PHASE_WIDTH-1:0] w_half_last;
         logic [C_PHASE_WIDTH-1:0] w_gap_last;

         assign w_half_last = C_PHASE_WIDTH'(r_period);
         assign w_gap_last  = (w_half_last + 1'b1) * C_GAP_MULT - 1'b1;
         assign w_sel[i]    = cfg_write && (cfg_channel == 4'(i));

         assign w_lit[i] = (r_mode == C_MODE_FOLLOW) ? led_in[i] :
                           (r_mode == C_MODE_BLINK)  ? (r_state == ST_ON) :
                           (r_mode == C_MODE_CODE)   ? ((r_count != 4'd0) && (r_state == ST_ON)) :
                                                       1'b0;

         // Value the channel shows right after a write, so the LED reacts in one clock.
         assign w_restart_lit[i] = (cfg_mode == C_MODE_FOLLOW) ? led_in[i] :
                                   (cfg_mode == C_MODE_BLINK)  ? 1'b1 :
                                   (cfg_mode == C_MODE_CODE)   ? (cfg_count != 4'd0) :
                                                                 1'b0;

         always_ff @(posedge int_clock) begin
            if (!int_reset) begin
               r_mode   <= C_MODE_OFF;
               r_period <= '0;
               r_count  <= '0;
               r_phase  <= '0;
               r_pulse  <= '0;
               r_state  <= ST_ON;
            end else if (w_sel[i]) begin
               r_mode   <= cfg_mode;
               r_period <= cfg_period;
               r_count  <= cfg_count;
               r_phase  <= '0;
               r_pulse  <= '0;
               r_state  <= ST_ON;
            end else if (r_tick) begin
               case (r_mode)
                  C_MODE_BLINK: begin
                     if (r_phase == w_half_last) begin
                        r_phase <= '0;
                        r_state <= (r_state == ST_ON) ? ST_OFF : ST_ON;
                     end else begin
                        r_phase <= r_phase + 1'b1;
                     end
                  end
                  C_MODE_CODE: begin
                     if (r_count != 4'd0) begin
                        case (r_state)
                           ST_ON: begin
                              if (r_phase == w_half_last) begin
                                 r_phase <= '0;
                                 r_state <= ST_OFF;
                              end else begin
                                 r_phase <= r_phase + 1'b1;
                              end
                           end
                           ST_OFF: begin
                              if (r_phase == w_half_last) begin
                                 r_phase <= '0;
                                 if (r_pulse + 4'd1 == r_count) begin
                                    r_pulse <= '0;
                                    r_state <= ST_GAP;
                                 end else begin
                                    r_pulse <= r_pulse + 4'd1;
                                    r_state <= ST_ON;
                                 end
                              end else begin
                                 r_phase <= r_phase + 1'b1;
                              end
                           end
                           ST_GAP: begin
                              if (r_phase == w_gap_last) begin
                                 r_phase <= '0;
                                 r_state <= ST_ON;
                              end else begin
                                 r_phase <= r_phase + 1'b1;
                              end
                           end
                           default: begin
                              r_phase <= '0;
                              r_state <= ST_ON;
                           end
                        endcase
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      end
   endgenerate

   logic w_gate;

`ifdef LED_STATUS_PWM_EN
   logic [3:0] r_pwm;

   always_ff @(posedge int_clock) begin
      if (!int_reset) begin
         r_pwm <= 4'd0;
      end else begin
         r_pwm <= r_pwm + 4'd1;
      end
   end

   assign w_gate = (r_pwm <= brightness);
`else
   // Without dimming the gate is always open; brightness is referenced only to keep the port tied in.
   assign w_gate = 1'b1 | (|brightness);
`endif

   always_ff @(posedge int_clock) begin
      if (!int_reset) begin
         leds <= '0;
      end else begin
         leds <= ((w_sel & w_restart_lit) | (~w_sel & w_lit)) & {NUM_LEDS{w_gate}};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_status_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_status_driver
// Purpose  : Self-checking bench for led_status_driver (PRESCALE = 4, 8 LEDs).
// Revision : 1.0
// ============================================================================
module tb_led_status_driver;

   localparam int NL = 8;
   localparam int PS = 4;
   localparam int PW = 10;

   logic          int_clock   = 1'b0;
   logic          int_reset   = 1'b0;
   logic [NL-1:0] led_in      = '0;
   logic          cfg_write   = 1'b0;
   logic [3:0]    cfg_channel = 4'd0;
   logic [1:0]    cfg_mode    = 2'd0;
   logic [PW-1:0] cfg_period  = '0;
   logic [3:0]    cfg_count   = 4'd0;
   logic [3:0]    brightness  = 4'hF;
   logic          tick;
   logic [NL-1:0] leds;

   led_status_driver #(
      .NUM_LEDS       (NL),
      .PRESCALE       (PS),
      .PRESCALE_WIDTH (3),
      .PERIOD_WIDTH   (PW),
      .GAP_MULT       (4)
   ) dut (
      .int_clock   (int_clock),
      .int_reset   (int_reset),
      .led_in      (led_in),
      .cfg_write   (cfg_write),
      .cfg_channel (cfg_channel),
      .cfg_mode    (cfg_mode),
      .cfg_period  (cfg_period),
      .cfg_count   (cfg_count),
      .brightness  (brightness),
      .tick        (tick),
      .leds        (leds)
   );

   always #5 int_clock = ~int_clock;

   typedef struct {
      string         name;
      logic [NL-1:0] leds;
      logic          tick;
   } exp_t;

   typedef struct {
      logic          w;
      logic [3:0]    ch;
      logic [1:0]    mode;
      logic [PW-1:0] per;
      logic [3:0]    cnt;
      logic [NL-1:0] lin;
      logic [NL-1:0] exp_leds;
   } vec_t;

   exp_t sb_q[$];
   vec_t tbl[13];
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   tb_cnt = 0;
   logic tb_tick = 1'b0;

   task automatic check(input string name, input logic [NL-1:0] act, input logic [NL-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // One clock: predict the prescaler tick, queue the expectation, then compare after the edge.
   task automatic step(input string name, input logic [NL-1:0] exp_leds);
      exp_t e;
      if (!int_reset) begin
         tb_cnt  = 0;
         tb_tick = 1'b0;
      end else begin
         tb_tick = (tb_cnt == PS - 1);
         tb_cnt  = tb_tick ? 0 : tb_cnt + 1;
      end
      e.name = name;
      e.leds = exp_leds;
      e.tick = tb_tick;
      sb_q.push_back(e);
      @(posedge int_clock);
      #1;
      e = sb_q.pop_front();
      check({e.name, "_leds"}, leds, e.leds);
      check({e.name, "_tick"}, {{(NL-1){1'b0}}, tick}, {{(NL-1){1'b0}}, e.tick});
      cfg_write = 1'b0;
   endtask

   task automatic wr(input logic [3:0] ch, input logic [1:0] mode, input logic [PW-1:0] per,
                     input logic [3:0] cnt);
      cfg_write   = 1'b1;
      cfg_channel = ch;
      cfg_mode    = mode;
      cfg_period  = per;
      cfg_count   = cnt;
   endtask

   // Run until the clock after which tick is high; the next edge consumes that tick.
   task automatic sync_tick(input logic [NL-1:0] cur);
      int n;
      n = 0;
      do begin
         step("sync", cur);
         n++;
      end while (!tb_tick && n < 2 * PS);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1'b1, 4'd5,  2'd1, 10'd0, 4'd0, 8'h00, 8'h00};
      tbl[1]  = '{1'b0, 4'd0,  2'd0, 10'd0, 4'd0, 8'h20, 8'h20};
      tbl[2]  = '{1'b0, 4'd0,  2'd0, 10'd0, 4'd0, 8'hFF, 8'h20};
      tbl[3]  = '{1'b0, 4'd0,  2'd0, 10'd0, 4'd0, 8'h00, 8'h00};
      tbl[4]  = '{1'b1, 4'd12, 2'd2, 10'd1, 4'd0, 8'h20, 8'h20};
      tbl[5]  = '{1'b1, 4'd13, 2'd0, 10'd0, 4'd0, 8'h20, 8'h20};
      tbl[6]  = '{1'b1, 4'd5,  2'd0, 10'd0, 4'd0, 8'h20, 8'h00};
      tbl[7]  = '{1'b1, 4'd5,  2'd1, 10'd0, 4'd0, 8'h20, 8'h20};
      tbl[8]  = '{1'b1, 4'd7,  2'd3, 10'd0, 4'd0, 8'h20, 8'h20};
      tbl[9]  = '{1'b1, 4'd6,  2'd2, 10'd5, 4'd0, 8'h20, 8'h60};
      tbl[10] = '{1'b1, 4'd6,  2'd0, 10'd0, 4'd0, 8'h20, 8'h20};
      tbl[11] = '{1'b1, 4'd5,  2'd3, 10'd9, 4'd2, 8'h00, 8'h20};
      tbl[12] = '{1'b1, 4'd5,  2'd0, 10'd0, 4'd0, 8'h00, 8'h00};

      // Reset held three clocks
      repeat (3) step("reset", 8'h00);
      int_reset = 1'b1;
      repeat (9) step("tick_run", 8'h00);

      // Follow mode, bad indices, restart values
      for (int r = 0; r < 13; r++) begin
         led_in = tbl[r].lin;
         if (tbl[r].w) wr(tbl[r].ch, tbl[r].mode, tbl[r].per, tbl[r].cnt);
         step($sformatf("vec%0d", r), tbl[r].exp_leds);
      end
      led_in = '0;

      // Blink ch2 period 1, written one clock after a consumed tick
      sync_tick(8'h00);
      step("pre_blink", 8'h00);
      wr(4'd2, 2'd2, 10'd1, 4'd0);
      for (int k = 0; k < 32; k++)
         step($sformatf("blink%0d", k), ((k / 8) % 2 == 0) ? 8'h04 : 8'h00);

      // Reset mid-blink, with a competing write
      int_reset = 1'b0;
      wr(4'd2, 2'd2, 10'd1, 4'd0);
      step("mid_reset", 8'h00);
      int_reset = 1'b1;
      repeat (4) step("post_reset", 8'h00);

      // Write coincides with tick consumption: tick ignored, phase restarts at 0
      sync_tick(8'h00);
      wr(4'd1, 2'd2, 10'd1, 4'd0);
      for (int k = 0; k < 25; k++)
         step($sformatf("collide%0d", k), (k < 9 || k >= 17) ? 8'h02 : 8'h00);
      wr(4'd1, 2'd0, 10'd0, 4'd0);
      step("collide_off", 8'h00);

      // Code mode ch0 period 0 count 3: three 4/4 pulses then 16 gap clocks
      sync_tick(8'h00);
      step("pre_code", 8'h00);
      wr(4'd0, 2'd3, 10'd0, 4'd3);
      for (int k = 0; k < 80; k++)
         step($sformatf("code%0d", k),
              (((k % 40) < 24) && ((((k % 40) / 4) % 2) == 0)) ? 8'h01 : 8'h00);
      wr(4'd0, 2'd0, 10'd0, 4'd0);
      step("code_off", 8'h00);

`ifdef LED_STATUS_PWM_EN
      begin
         int hi;
         led_in     = 8'h08;
         brightness = 4'd3;
         wr(4'd3, 2'd1, 10'd0, 4'd0);
         @(posedge int_clock);
         #1;
         cfg_write = 1'b0;
         hi = 0;
         for (int k = 0; k < 16; k++) begin
            @(posedge int_clock);
            #1;
            if (leds[3]) hi++;
         end
         check("pwm_b3_count", NL'(hi), NL'(4));
         check("pwm_b3_others", leds & 8'hF7, 8'h00);
         brightness = 4'd15;
         @(posedge int_clock);
         #1;
         hi = 0;
         for (int k = 0; k < 16; k++) begin
            @(posedge int_clock);
            #1;
            if (leds[3]) hi++;
         end
         check("pwm_b15_count", NL'(hi), NL'(16));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
